sram_mem_stage: RTL and testbench

Memory stage of the five-stage MIPS pipeline. It sits between the EXE stage register and the MEM stage register and services load/store requests against an external 16-bit asynchronous SRAM. Each 32-bit word access is split into two 16-bit SRAM accesses. A `ready` signal freezes the whole pipeline while an access is in flight, and a 32-bit read result is presented to the MEM stage register.

---
 rtl/mips_pkg.sv | 16 +
 rtl/sram_mem_stage.sv | 128 ++++++++++++
 tb/tb_sram_mem_stage.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Holds the memory-stage FSM states and the SRAM geometry defaults.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int          SRAM_DATA_W    = 16;
    localparam int          SRAM_ADDR_W    = 18;
    localparam logic [31:0] DATA_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_mem_stage.sv
// MIPS memory stage: splits each 32-bit load/store into two 16-bit accesses
// on an asynchronous SRAM and freezes the pipeline with ready while busy.
module sram_mem_stage
    import mips_pkg::*;
#(
    parameter int          ADDR_W      = SRAM_ADDR_W,
    parameter logic [31:0] BASE_ADDR   = DATA_BASE_ADDR,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_En,
    input  logic                   MEM_W_En,
    input  logic [31:0]            ALU_result,
    input  logic [31:0]            store_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [ADDR_W-1:0]      SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    localparam int         WORD_W    = ADDR_W - 1;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    mem_state_e              state, state_nxt;
    logic [2:0]              wait_cnt, wait_cnt_nxt;
    logic                    req;
    logic                    phase_last;
    logic [31:0]             offset;
    logic [WORD_W-1:0]       word_in, word_q, word_cur;
    logic [31:0]             data_q, data_cur;
    logic                    wr_q, wr_cur;
    logic [ADDR_W-1:0]       sram_addr_nxt;
    logic                    we_n_nxt, oe_n_nxt;
    logic                    dq_drive, dq_drive_nxt;
    logic [SRAM_DATA_W-1:0]  dq_out_q, dq_out_nxt;
    logic                    unused_addr_bits;

    assign req        = MEM_R_En | MEM_W_En;
    assign offset     = ALU_result - BASE_ADDR;
    assign word_in    = offset[WORD_W+1:2];
    assign phase_last = (wait_cnt == WAIT_LAST);
    assign ready      = (state == DONE) | ((state == IDLE) & ~req);
    assign SRAM_DQ    = dq_drive ? dq_out_q : {SRAM_DATA_W{1'bz}};

    // Byte offset and bits beyond the SRAM size are dropped, so addresses wrap.
    assign unused_addr_bits = ^{offset[31:WORD_W+2], offset[1:0]};

    // The latch happens on the IDLE->LOW edge, so the first phase uses the live inputs.
    always_comb begin
        word_cur = (state == IDLE) ? word_in    : word_q;
        data_cur = (state == IDLE) ? store_data : data_q;
        wr_cur   = (state == IDLE) ? MEM_W_En   : wr_q;
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: if (req) state_nxt = LOW;
            LOW: begin
                if (phase_last) begin
                    state_nxt    = HIGH;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_nxt    = DONE;
                    wait_cnt_nxt = 3'd0;
                end else begin
                    wait_cnt_nxt = wait_cnt + 3'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Bus strobes are registered from the next state so they are glitch-free.
        sram_addr_nxt = SRAM_ADDR;
        we_n_nxt      = 1'b1;
        oe_n_nxt      = 1'b1;
        dq_drive_nxt  = 1'b0;
        dq_out_nxt    = dq_out_q;
        if (state_nxt == LOW || state_nxt == HIGH) begin
            sram_addr_nxt = {word_cur, (state_nxt == HIGH)};
            we_n_nxt      = ~wr_cur;
            oe_n_nxt      = wr_cur;
            dq_drive_nxt  = wr_cur;
            dq_out_nxt    = (state_nxt == HIGH) ? data_cur[31:16] : data_cur[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            dq_drive  <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            SRAM_ADDR <= sram_addr_nxt;
            SRAM_WE_N <= we_n_nxt;
            SRAM_OE_N <= oe_n_nxt;
            dq_drive  <= dq_drive_nxt;
            if (!wr_q && phase_last && state == LOW)  read_data[15:0]  <= SRAM_DQ;
            if (!wr_q && phase_last && state == HIGH) read_data[31:16] <= SRAM_DQ;
        end
    end

    always_ff @(posedge clk) begin
        dq_out_q <= dq_out_nxt;
        if (state == IDLE && req) begin
            word_q <= word_in;
            data_q <= store_data;
            wr_q   <= MEM_W_En;
        end
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: two instances (WAIT_CYCLES 1 and 0), each on its
// own behavioural SRAM, checked through a completion scoreboard.
module tb_sram_mem_stage;
    import mips_pkg::*;

    localparam int AW = 18;

    typedef struct {
        int          sel;
        bit          is_read;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        r_en1 = 0, w_en1 = 0, r_en0 = 0, w_en0 = 0;
    logic [31:0] alu1 = 0, sd1 = 0, alu0 = 0, sd0 = 0;
    logic [31:0] rdata1, rdata0;
    logic        ready1, ready0, we_n1, we_n0, oe_n1, oe_n0;
    logic [AW-1:0] addr1, addr0;
    wire  [15:0] dq1, dq0;

    bit [15:0] mem1 [0:(1<<AW)-1];
    bit [15:0] mem0 [0:(1<<AW)-1];

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;
    int   mon_cyc = 0;
    bit   mon_we_seen = 0;
    bit   m_req, m_rdy, m_we_n;
    logic [31:0] m_rd;
    time  last_ready_t = 0, prev_ready_t = 0;

    always #5 clk = ~clk;

    sram_mem_stage #(.ADDR_W(AW), .BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .MEM_R_En(r_en1), .MEM_W_En(w_en1),
        .ALU_result(alu1), .store_data(sd1), .read_data(rdata1), .ready(ready1),
        .SRAM_DQ(dq1), .SRAM_ADDR(addr1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1)
    );

    sram_mem_stage #(.ADDR_W(AW), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .MEM_R_En(r_en0), .MEM_W_En(w_en0),
        .ALU_result(alu0), .store_data(sd0), .read_data(rdata0), .ready(ready0),
        .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_WE_N(we_n0), .SRAM_OE_N(oe_n0)
    );

    // SRAM models: combinational read; each write-enabled cycle stores the
    // halfword on the bus, which is what a WE_N rising edge per phase commits.
    assign dq1 = oe_n1 ? 16'hzzzz : mem1[addr1];
    assign dq0 = oe_n0 ? 16'hzzzz : mem0[addr0];
    always @(posedge clk) if (!we_n1) mem1[addr1] <= dq1;
    always @(posedge clk) if (!we_n0) mem0[addr0] <= dq0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 1) begin r_en1 = rd; w_en1 = wr; alu1 = a; sd1 = d; end
        else          begin r_en0 = rd; w_en0 = wr; alu0 = a; sd0 = d; end
    endtask

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic access(input int sel, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input int exp_lat);
        exp_t e;
        bit   done;
        e.sel = sel; e.is_read = rd & ~wr; e.rd = exp_rd; e.lat = exp_lat;
        sb.push_back(e);
        drive(sel, rd, wr, a, d);
        done = 0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            done = (sel == 1) ? ready1 : ready0;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_timeout: dut %0d addr %h never raised ready", sel, a);
        end
        @(posedge clk); #1;
        drive(sel, 0, 0, 0, 0);
    endtask

    // Monitor: counts cycles of the open request and checks each completion.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            mon_cyc = 0; mon_we_seen = 0;
        end else if (sb.size() > 0) begin
            if (sb[0].sel == 1) begin
                m_req = r_en1 | w_en1; m_rdy = ready1; m_we_n = we_n1; m_rd = rdata1;
            end else begin
                m_req = r_en0 | w_en0; m_rdy = ready0; m_we_n = we_n0; m_rd = rdata0;
            end
            if (m_req) begin
                mon_cyc++;
                if (!m_we_n) mon_we_seen = 1;
                if (m_rdy) begin
                    mon_e = sb.pop_front();
                    chk("latency", mon_cyc, mon_e.lat);
                    chk("read_data", m_rd, mon_e.rd);
                    if (mon_e.is_read) chk("load_we_n_idle", {31'd0, mon_we_seen}, 32'd0);
                    prev_ready_t = last_ready_t;
                    last_ready_t = $time;
                    mon_cyc = 0; mon_we_seen = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready1}, 32'd1);
        chk("rst_read_data", rdata1, 32'd0);
        chk("rst_addr", {14'd0, addr1}, 32'd0);
        chk("rst_bus", {29'd0, we_n1, oe_n1, u_dut1.dq_drive}, 32'b110);
        w_en1 = 1; #1;
        chk("rst_ready_req", {31'd0, ready1}, 32'd0);
        w_en1 = 0;
        @(negedge clk) rst = 1;
        @(posedge clk); #1;

        // Reset during the HIGH phase of a store
        drive(1, 0, 1, 32'd1032, 32'h5555AAAA);
        repeat (3) @(posedge clk);
        #1;
        chk("high_we_n", {31'd0, we_n1}, 32'd0);
        chk("high_addr", {14'd0, addr1}, 32'd5);
        rst = 0; #1;
        chk("rst_mid_bus", {29'd0, we_n1, oe_n1, u_dut1.dq_drive}, 32'b110);
        drive(1, 0, 0, 0, 0);
        @(negedge clk) rst = 1;
        @(negedge clk);
        chk("rst_mid_state", 32'(u_dut1.state), 32'(IDLE));
        chk("rst_mid_read_data", rdata1, 32'd0);
        chk("partial_low", {16'd0, mem1[4]}, 32'h0000AAAA);
        chk("partial_high", {16'd0, mem1[5]}, 32'h00000000);
        @(posedge clk); #1;

        // Store, then load back (W=1)
        access(1, 0, 1, 32'd1032, 32'hDEADBEEF, 32'd0, 6);
        chk("store_lo", {16'd0, mem1[4]}, 32'h0000BEEF);
        chk("store_hi", {16'd0, mem1[5]}, 32'h0000DEAD);
        access(1, 1, 0, 32'd1032, 32'd0, 32'hDEADBEEF, 6);

        // Back-to-back store and load
        access(1, 0, 1, 32'd1040, 32'h12345678, 32'hDEADBEEF, 6);
        access(1, 1, 0, 32'd1040, 32'd0, 32'h12345678, 6);
        chk("b2b_spacing", 32'(last_ready_t - prev_ready_t), 32'd60);
        chk("b2b_lo", {16'd0, mem1[8]}, 32'h00005678);
        chk("b2b_hi", {16'd0, mem1[9]}, 32'h00001234);

        // Both enables: handled as a store
        access(1, 1, 1, 32'd1024, 32'hCAFE0001, 32'h12345678, 6);
        chk("conf_lo", {16'd0, mem1[0]}, 32'h00000001);
        chk("conf_hi", {16'd0, mem1[1]}, 32'h0000CAFE);

        // W=0 with an address that wraps to word 0
        access(0, 0, 1, 32'd1024 + 32'd4 * (32'd1 << 17), 32'hA5A55A5A, 32'd0, 4);
        chk("wrap_lo", {16'd0, mem0[0]}, 32'h00005A5A);
        chk("wrap_hi", {16'd0, mem0[1]}, 32'h0000A5A5);
        access(0, 1, 0, 32'd1024, 32'd0, 32'hA5A55A5A, 4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_bus", {28'd0, ready0, we_n0, oe_n0, u_dut0.dq_drive}, 32'b1110);
        end

        chk("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
